dmem_agu: RTL and testbench

Data-memory address generator and access sequencer; the memory-side responder to the control unit's data-path strobes (dmem_read, dmem_write, mar_inc, col_inc, row_inc, col_zero). It keeps the memory address register (MAR) and a row/column traversal position over an image of programmable dimensions. It forms the linear data-memory address and runs single-word read and write transactions against a synchronous SRAM with fixed read latency. It returns read data and status to the datapath.

---
 rtl/dmem_agu.sv | 236 +++++++++++++++++++++++
 tb/tb_dmem_agu.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_agu.sv
// dmem_agu: data-memory address generator and access sequencer.
// Keeps the MAR and a row/column traversal position over an image of
// programmable size, forms address = MAR + row*n_cols + col without a
// multiplier, and runs single-word read/write transactions against a
// synchronous SRAM with a fixed read latency of MEM_LAT cycles.
//
// Handshake: dmem_read/dmem_write are single-cycle strobes sampled at a
// rising edge. A strobe is accepted only while busy is low; a strobe that
// arrives while busy is high is dropped and sets the sticky err flag.
// A simultaneous read+write performs the write, drops the read and sets err.
// A read completes with a one-cycle rdata_valid pulse; busy is already low in
// that cycle, so a new strobe at that edge is accepted.
`timescale 1ns/1ps

module dmem_agu #(
    parameter int BUS_WIDTH = 16,
    parameter int ADDR_W    = 12,
    parameter int ROW_W     = 8,
    parameter int COL_W     = 8,
    parameter int MEM_LAT   = 2,
    parameter int DEF_COLS  = 8,
    parameter int DEF_ROWS  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 dmem_read,
    input  logic                 dmem_write,
    input  logic                 mar_inc,
    input  logic                 col_inc,
    input  logic                 row_inc,
    input  logic                 col_zero,
    input  logic                 mar_load,
    input  logic [ADDR_W-1:0]    mar_din,
    input  logic                 dim_load,
    input  logic [COL_W-1:0]     n_cols,
    input  logic [ROW_W-1:0]     n_rows,
    input  logic [BUS_WIDTH-1:0] wdata,
    output logic [BUS_WIDTH-1:0] rdata,
    output logic                 rdata_valid,
    output logic                 busy,
    output logic                 err,
    output logic                 frame_done,
    output logic [ROW_W-1:0]     row,
    output logic [COL_W-1:0]     col,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [BUS_WIDTH-1:0] mem_wdata,
    input  logic [BUS_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_RD_CAP  = 2'd2,
        S_WR      = 2'd3
    } state_t;

    // Last latency count in RD_WAIT: capture happens MEM_LAT edges after the
    // edge that ended the mem_en cycle.
    localparam logic [2:0] LAT_LAST = 3'(MEM_LAT);

    state_t              state;
    logic [2:0]          lat_cnt;

    logic [ADDR_W-1:0]   mar;
    logic [ADDR_W-1:0]   offset;     // row*n_cols + col, mod 2^ADDR_W
    logic [ADDR_W-1:0]   row_start;  // row*n_cols, mod 2^ADDR_W
    logic [COL_W-1:0]    cols_q;
    logic [ROW_W-1:0]    rows_q;

    logic [ADDR_W-1:0]   cols_ext;
    logic [ADDR_W-1:0]   next_row_start;
    logic [ADDR_W-1:0]   addr_now;
    logic                row_last;
    logic                col_last;
    logic                access_strobe;

    // Address and position helpers derived from the current pointer state.
    always_comb begin
        cols_ext       = ADDR_W'(cols_q);
        next_row_start = row_start + cols_ext;
        addr_now       = mar + offset;
        row_last       = (row == (rows_q - 1'b1));
        col_last       = (col == (cols_q - 1'b1));
        access_strobe  = dmem_read | dmem_write;
    end

    // MAR, dimensions and row/column/offset pointer updates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mar        <= '0;
            offset     <= '0;
            row_start  <= '0;
            row        <= '0;
            col        <= '0;
            cols_q     <= COL_W'(DEF_COLS);
            rows_q     <= ROW_W'(DEF_ROWS);
            frame_done <= 1'b0;
        end else begin
            if (mar_load) begin
                mar        <= mar_din;
                frame_done <= 1'b0;
            end else if (mar_inc) begin
                mar <= mar + 1'b1;
            end

            if (dim_load) begin
                cols_q     <= n_cols;
                rows_q     <= n_rows;
                row        <= '0;
                col        <= '0;
                offset     <= '0;
                row_start  <= '0;
                frame_done <= 1'b0;
            end else if (row_inc) begin
                if (row_last) begin
                    // Frame wrap: back to the origin.
                    row        <= '0;
                    col        <= '0;
                    offset     <= '0;
                    row_start  <= '0;
                    frame_done <= 1'b1;
                end else begin
                    row       <= row + 1'b1;
                    row_start <= next_row_start;
                    if (col_zero) begin
                        col    <= '0;
                        offset <= next_row_start;
                    end else begin
                        offset <= offset + cols_ext;
                    end
                end
            end else if (col_inc) begin
                if (col_last) begin
                    if (row_last) begin
                        row        <= '0;
                        col        <= '0;
                        offset     <= '0;
                        row_start  <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        // Last column: offset+1 lands exactly on the next row start.
                        row       <= row + 1'b1;
                        col       <= '0;
                        offset    <= offset + 1'b1;
                        row_start <= next_row_start;
                    end
                end else begin
                    col    <= col + 1'b1;
                    offset <= offset + 1'b1;
                end
            end else if (col_zero) begin
                // Stand-alone col_zero returns to the start of the current row.
                col    <= '0;
                offset <= row_start;
            end
        end
    end

    // Access sequencer: accepts strobes, drives the SRAM port, captures read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            lat_cnt     <= '0;
            busy        <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            case (state)
                S_IDLE, S_RD_CAP: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (dmem_write) begin
                        // Write wins over a simultaneous read; the read is dropped.
                        state     <= S_WR;
                        busy      <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_now;
                        mem_wdata <= wdata;
                        if (dmem_read) begin
                            err <= 1'b1;
                        end
                    end else if (dmem_read) begin
                        state    <= S_RD_WAIT;
                        busy     <= 1'b1;
                        mem_en   <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= addr_now;
                        lat_cnt  <= '0;
                    end
                end
                S_WR: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (access_strobe) begin
                        err <= 1'b1;
                    end
                end
                S_RD_WAIT: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (access_strobe) begin
                        err <= 1'b1;
                    end
                    if (lat_cnt == LAT_LAST) begin
                        state       <= S_RD_CAP;
                        busy        <= 1'b0;
                        rdata       <= mem_rdata;
                        rdata_valid <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_agu.sv
// Directed bench for dmem_agu: reset state, write/read timing, image
// traversal with auto-wrap, row_inc priority, protocol errors, address
// wraparound and asynchronous reset in the middle of a read.
`timescale 1ns/1ps

module tb_dmem_agu;

    localparam int BW  = 16;
    localparam int AW  = 12;
    localparam int RW  = 8;
    localparam int CW  = 8;
    localparam int LAT = 2;

    logic          clk;
    logic          reset_n;
    logic          dmem_read, dmem_write;
    logic          mar_inc, col_inc, row_inc, col_zero, mar_load, dim_load;
    logic [AW-1:0] mar_din;
    logic [CW-1:0] n_cols;
    logic [RW-1:0] n_rows;
    logic [BW-1:0] wdata;
    logic [BW-1:0] rdata;
    logic          rdata_valid, busy, err, frame_done;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [AW-1:0] mem_addr;
    logic          mem_en, mem_we;
    logic [BW-1:0] mem_wdata;
    logic [BW-1:0] mem_rdata;

    int checks;
    int failures;

    dmem_agu #(
        .BUS_WIDTH(BW), .ADDR_W(AW), .ROW_W(RW), .COL_W(CW),
        .MEM_LAT(LAT), .DEF_COLS(8), .DEF_ROWS(8)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .mar_inc(mar_inc), .col_inc(col_inc), .row_inc(row_inc), .col_zero(col_zero),
        .mar_load(mar_load), .mar_din(mar_din),
        .dim_load(dim_load), .n_cols(n_cols), .n_rows(n_rows),
        .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid),
        .busy(busy), .err(err), .frame_done(frame_done),
        .row(row), .col(col),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: data valid only in the cycle LAT cycles after the mem_en cycle.
    logic [BW-1:0] sram [0:(1<<AW)-1];
    logic [BW-1:0] pipe_d [0:3];
    logic          pipe_v [0:3];

    always @(posedge clk) begin
        if (mem_en && mem_we) sram[mem_addr] <= mem_wdata;
        pipe_v[0] <= mem_en && !mem_we;
        pipe_d[0] <= sram[mem_addr];
        for (int i = 1; i < 4; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end

    assign mem_rdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : 16'hDEAD;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // One clock: the posedge samples the inputs, outputs are observed at the negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        dmem_read = 0; dmem_write = 0; mar_inc = 0; col_inc = 0; row_inc = 0;
        col_zero = 0; mar_load = 0; dim_load = 0;
        mar_din = '0; n_cols = '0; n_rows = '0; wdata = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_rvalid", rdata_valid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", err, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_row", row, 0);
        chk("rst_col", col, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        reset_n = 1'b1;
        tick();

        // Write 0xBEEF at MAR 0x100
        mar_din = 12'h100; mar_load = 1; tick(); mar_load = 0;
        wdata = 16'hBEEF; dmem_write = 1; tick(); dmem_write = 0;
        chk("wr_mem_en", mem_en, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, 32'h100);
        chk("wr_mem_wdata", mem_wdata, 32'hBEEF);
        chk("wr_busy", busy, 1);
        tick();
        chk("wr_done_en", mem_en, 0);
        chk("wr_done_we", mem_we, 0);
        chk("wr_done_busy", busy, 0);

        // Read back 0x100: mem_en at k+1, rdata_valid at k+4
        dmem_read = 1; tick(); dmem_read = 0;
        chk("rd_k1_en", mem_en, 1);
        chk("rd_k1_we", mem_we, 0);
        chk("rd_k1_addr", mem_addr, 32'h100);
        chk("rd_k1_busy", busy, 1);
        tick();
        chk("rd_k2_en", mem_en, 0);
        chk("rd_k2_busy", busy, 1);
        chk("rd_k2_rv", rdata_valid, 0);
        tick();
        chk("rd_k3_busy", busy, 1);
        chk("rd_k3_rv", rdata_valid, 0);
        tick();
        chk("rd_k4_rv", rdata_valid, 1);
        chk("rd_k4_rdata", rdata, 32'hBEEF);
        chk("rd_k4_busy", busy, 0);
        tick();
        chk("rd_k5_rv", rdata_valid, 0);
        chk("rd_k5_rdata_held", rdata, 32'hBEEF);

        // 3x2 image at MAR 0x10: six column steps cover 0x10..0x15 and wrap
        n_cols = 8'd3; n_rows = 8'd2; dim_load = 1;
        mar_din = 12'h010; mar_load = 1; tick(); dim_load = 0; mar_load = 0;
        chk("dim_row", row, 0);
        chk("dim_col", col, 0);
        for (int i = 0; i < 6; i++) begin
            wdata = BW'(i); dmem_write = 1; tick(); dmem_write = 0;
            chk($sformatf("trav_addr_%0d", i), mem_addr, 32'h10 + i);
            col_inc = 1; tick(); col_inc = 0;
            chk($sformatf("trav_row_%0d", i), row, ((i + 1) % 6) / 3);
            chk($sformatf("trav_col_%0d", i), col, ((i + 1) % 6) % 3);
            chk($sformatf("trav_fd_%0d", i), frame_done, (i == 5) ? 1 : 0);
        end

        // row_inc+col_zero beats col_inc at row 0, col 2
        col_inc = 1; tick(); tick(); col_inc = 0;
        chk("pri_pre_col", col, 2);
        chk("pri_pre_row", row, 0);
        row_inc = 1; col_zero = 1; col_inc = 1; tick();
        row_inc = 0; col_zero = 0; col_inc = 0;
        chk("pri_row", row, 1);
        chk("pri_col", col, 0);
        chk("pri_fd_sticky", frame_done, 1);
        wdata = 16'h5A5A; dmem_write = 1; tick(); dmem_write = 0;
        chk("pri_addr", mem_addr, 32'h13);
        tick();

        // Read strobe during RD_WAIT is dropped and sets err
        chk("err_pre", err, 0);
        dmem_read = 1; tick(); tick(); dmem_read = 0;
        chk("busyrd_err", err, 1);
        chk("busyrd_busy", busy, 1);
        chk("busyrd_rv_k2", rdata_valid, 0);
        tick();
        chk("busyrd_rv_k3", rdata_valid, 0);
        tick();
        chk("busyrd_rv_k4", rdata_valid, 1);
        chk("busyrd_rdata", rdata, 32'h5A5A);
        tick();
        chk("busyrd_rv_k5", rdata_valid, 0);
        chk("busyrd_busy_k5", busy, 0);
        tick();
        chk("busyrd_rv_k6", rdata_valid, 0);
        chk("err_sticky", err, 1);

        // Reset to clear err, then read+write together
        reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
        chk("rst2_err", err, 0);
        mar_din = 12'h200; mar_load = 1; tick(); mar_load = 0;
        wdata = 16'h1234; dmem_read = 1; dmem_write = 1; tick();
        dmem_read = 0; dmem_write = 0;
        chk("rw_mem_en", mem_en, 1);
        chk("rw_mem_we", mem_we, 1);
        chk("rw_mem_addr", mem_addr, 32'h200);
        chk("rw_mem_wdata", mem_wdata, 32'h1234);
        chk("rw_err", err, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rw_no_rv_%0d", i), rdata_valid, 0);
            chk($sformatf("rw_idle_%0d", i), busy, 0);
        end
        dmem_read = 1; tick(); dmem_read = 0;
        tick(); tick(); tick();
        chk("rw_rb_rv", rdata_valid, 1);
        chk("rw_rb_rdata", rdata, 32'h1234);
        tick();

        // MAR 0xFFE, mar_inc -> 0xFFF, offset 2 -> address wraps to 0x001
        mar_din = 12'hFFE; mar_load = 1; col_inc = 1; tick();
        mar_load = 0; mar_inc = 1; tick(); mar_inc = 0; col_inc = 0;
        chk("wrap_col", col, 2);
        dmem_read = 1; tick(); dmem_read = 0;
        chk("wrap_addr", mem_addr, 32'h001);
        chk("wrap_en", mem_en, 1);
        chk("wrap_busy", busy, 1);

        // Asynchronous reset in the middle of the read
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_mem_en", mem_en, 0);
        chk("arst_mem_we", mem_we, 0);
        chk("arst_rv", rdata_valid, 0);
        chk("arst_rdata", rdata, 0);
        chk("arst_err", err, 0);
        chk("arst_col", col, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_mem_wdata", mem_wdata, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("arst_no_rv_%0d", i), rdata_valid, 0);
        end

        // row_inc without col_zero keeps the column; last row wraps the frame
        n_cols = 8'd5; n_rows = 8'd4; dim_load = 1; tick(); dim_load = 0;
        col_inc = 1; tick(); col_inc = 0;
        row_inc = 1; tick(); row_inc = 0;
        chk("rk_row", row, 1);
        chk("rk_col", col, 1);
        wdata = 16'h0077; dmem_write = 1; tick(); dmem_write = 0;
        chk("rk_addr", mem_addr, 32'h006);
        tick();
        row_inc = 1; tick(); tick();
        chk("rk_row3", row, 3);
        chk("rk_fd_pre", frame_done, 0);
        tick(); row_inc = 0;
        chk("rk_wrap_row", row, 0);
        chk("rk_wrap_col", col, 0);
        chk("rk_wrap_fd", frame_done, 1);
        dim_load = 1; tick(); dim_load = 0;
        chk("dim_clears_fd", frame_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
